// File: rtl/hazard5_imem_responder.sv
// Instruction-memory responder for the frontend fetch port: AHB-lite-style
// address/data pipeline over a synchronous word RAM with a byte-lane backdoor writer.
module hazard5_imem_responder #(
  parameter int                W_ADDR      = 32,
  parameter int                W_DATA      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [W_ADDR-1:0] BASE_ADDR   = {W_ADDR{1'b0}},
  parameter int                WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_size,
  input  logic [W_ADDR-1:0] mem_addr,
  input  logic              mem_addr_vld,
  output logic              mem_addr_rdy,
  output logic [W_DATA-1:0] mem_data,
  output logic              mem_data_vld,
  input  logic              stall_in,
  output logic              err,
  input  logic              wr_en,
  input  logic [W_ADDR-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_byte_en,
  output logic [15:0]       fetch_count
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [W_ADDR:0] SPAN    = (W_ADDR + 1)'(DEPTH * 4);
  localparam logic [3:0]      WS_INIT = 4'(WAIT_STATES);

  logic [31:0]   ram_r [DEPTH];
  logic          dph_active_r;
  logic          dph_err_r;
  logic [31:0]   rdata_r;
  logic [31:0]   hold_data_r;
  logic [3:0]    wait_ctr_r;
  logic [15:0]   fetch_count_r;

  logic          hready_s;
  logic          accept_s;
  logic          req_err_s;
  logic          wr_hit_s;
  logic [W_ADDR:0] rd_diff_s;
  logic [W_ADDR:0] wr_diff_s;
  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] wr_idx_s;

  // Address decode, range/alignment checks and handshake ready.
  always_comb begin
    // The extra MSB is a borrow: addresses below BASE_ADDR become larger than SPAN.
    rd_diff_s = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
    wr_diff_s = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
    rd_idx_s  = rd_diff_s[AW+1:2];
    wr_idx_s  = wr_diff_s[AW+1:2];
    hready_s  = !dph_active_r || (wait_ctr_r == 4'd0 && !stall_in);
    accept_s  = mem_addr_vld && hready_s;
    req_err_s = (rd_diff_s >= SPAN) || mem_addr[0] || (mem_size && mem_addr[1]);
    wr_hit_s  = wr_en && (wr_diff_s < SPAN);
  end

  assign mem_addr_rdy = hready_s;
  assign mem_data_vld = dph_active_r && hready_s;
  assign mem_data     = mem_data_vld ? rdata_r : hold_data_r;
  assign err          = mem_data_vld && dph_err_r;
  assign fetch_count  = fetch_count_r;

  // Backdoor byte-lane writes; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_hit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_byte_en[b]) begin
          ram_r[wr_idx_s][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Data-phase state, captured read data and completed-fetch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dph_active_r  <= 1'b0;
      dph_err_r     <= 1'b0;
      rdata_r       <= 32'd0;
      hold_data_r   <= 32'd0;
      wait_ctr_r    <= 4'd0;
      fetch_count_r <= 16'd0;
    end else begin
      if (mem_data_vld) begin
        hold_data_r   <= rdata_r;
        fetch_count_r <= fetch_count_r + 16'd1;
      end
      if (accept_s) begin
        dph_active_r <= 1'b1;
        wait_ctr_r   <= WS_INIT;
        dph_err_r    <= req_err_s;
        // Read-before-write: a same-cycle backdoor write lands after this sample.
        rdata_r      <= req_err_s ? 32'd0 : ram_r[rd_idx_s];
      end else begin
        if (mem_data_vld) begin
          dph_active_r <= 1'b0;
        end
        if (dph_active_r && wait_ctr_r != 4'd0) begin
          wait_ctr_r <= wait_ctr_r - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard5_imem_responder.sv
// Directed bench for hazard5_imem_responder: one instance with no wait states and
// one with two, sharing all inputs except the address-valid strobe.
module tb_hazard5_imem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_size = 1'b1;
  logic [31:0] mem_addr = 32'd0;
  logic        vld0 = 1'b0;
  logic        vld2 = 1'b0;
  logic        stall_in = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_byte_en = 4'd0;

  logic        rdy0, dv0, err0, rdy2, dv2, err2;
  logic [31:0] data0, data2;
  logic [15:0] cnt0, cnt2;

  int n_vectors = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  hazard5_imem_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(1024),
                           .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_addr_vld(vld0), .mem_addr_rdy(rdy0), .mem_data(data0),
    .mem_data_vld(dv0), .stall_in(stall_in), .err(err0), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
    .fetch_count(cnt0)
  );

  hazard5_imem_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(1024),
                           .BASE_ADDR(BASE), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_addr_vld(vld2), .mem_addr_rdy(rdy2), .mem_data(data2),
    .mem_data_vld(dv2), .stall_in(stall_in), .err(err2), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
    .fetch_count(cnt2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_byte_en = be;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b0;
    step();
    check_val("rst_rdy", {31'd0, rdy0}, 32'd1);
    check_val("rst_dv", {31'd0, dv0}, 32'd0);
    check_val("rst_err", {31'd0, err0}, 32'd0);
    check_val("rst_data", data0, 32'd0);
    check_val("rst_cnt", {16'd0, cnt0}, 32'd0);

    // Preload and back-to-back fetches with no wait states
    bd_write(BASE, 32'h0000_0013, 4'hF);
    bd_write(BASE + 32'd4, 32'h0010_0093, 4'hF);
    mem_size = 1'b1; mem_addr = BASE; vld0 = 1'b1;
    #1;
    check_val("b2b_rdy0", {31'd0, rdy0}, 32'd1);
    check_val("b2b_dv0", {31'd0, dv0}, 32'd0);
    step();
    mem_addr = BASE + 32'd4;
    #1;
    check_val("b2b_rdy1", {31'd0, rdy0}, 32'd1);
    check_val("b2b_dv1", {31'd0, dv0}, 32'd1);
    check_val("b2b_data1", data0, 32'h0000_0013);
    check_val("b2b_err1", {31'd0, err0}, 32'd0);
    step();
    vld0 = 1'b0;
    #1;
    check_val("b2b_rdy2", {31'd0, rdy0}, 32'd1);
    check_val("b2b_dv2", {31'd0, dv0}, 32'd1);
    check_val("b2b_data2", data0, 32'h0010_0093);
    step();
    check_val("b2b_idle_dv", {31'd0, dv0}, 32'd0);
    check_val("b2b_hold", data0, 32'h0010_0093);
    check_val("b2b_cnt", {16'd0, cnt0}, 32'd2);

    // Two wait states with a request held through the stall
    mem_addr = BASE; vld2 = 1'b1;
    #1;
    check_val("ws_rdy_n", {31'd0, rdy2}, 32'd1);
    step();
    mem_addr = BASE + 32'd4;
    #1;
    check_val("ws_rdy_n1", {31'd0, rdy2}, 32'd0);
    check_val("ws_dv_n1", {31'd0, dv2}, 32'd0);
    step();
    check_val("ws_rdy_n2", {31'd0, rdy2}, 32'd0);
    check_val("ws_dv_n2", {31'd0, dv2}, 32'd0);
    step();
    check_val("ws_rdy_n3", {31'd0, rdy2}, 32'd1);
    check_val("ws_dv_n3", {31'd0, dv2}, 32'd1);
    check_val("ws_data_n3", data2, 32'h0000_0013);
    step();
    vld2 = 1'b0;
    #1;
    check_val("ws_rdy_n4", {31'd0, rdy2}, 32'd0);
    check_val("ws_hold_n4", data2, 32'h0000_0013);
    step();
    check_val("ws_dv_n5", {31'd0, dv2}, 32'd0);
    step();
    check_val("ws_dv_n6", {31'd0, dv2}, 32'd1);
    check_val("ws_data_n6", data2, 32'h0010_0093);
    step();
    check_val("ws_cnt", {16'd0, cnt2}, 32'd2);

    // Halfword fetch from the upper half of word 1
    bd_write(BASE + 32'd4, 32'hABCD_1234, 4'hF);
    mem_size = 1'b0; mem_addr = BASE + 32'd6; vld0 = 1'b1;
    step();
    vld0 = 1'b0;
    #1;
    check_val("hw_dv", {31'd0, dv0}, 32'd1);
    check_val("hw_data", data0, 32'hABCD_1234);
    check_val("hw_err", {31'd0, err0}, 32'd0);
    step();

    // Illegal accesses: misaligned word, past the end, below base, odd halfword
    mem_size = 1'b1; mem_addr = BASE + 32'd2; vld0 = 1'b1;
    step();
    mem_addr = BASE + 32'd4096;
    #1;
    check_val("ill_mis_err", {31'd0, err0}, 32'd1);
    check_val("ill_mis_data", data0, 32'd0);
    step();
    mem_addr = BASE - 32'd4;
    #1;
    check_val("ill_end_err", {31'd0, err0}, 32'd1);
    check_val("ill_end_data", data0, 32'd0);
    step();
    mem_size = 1'b0; mem_addr = BASE + 32'd1;
    #1;
    check_val("ill_low_err", {31'd0, err0}, 32'd1);
    check_val("ill_low_data", data0, 32'd0);
    step();
    mem_size = 1'b1; mem_addr = BASE + 32'd4;
    #1;
    check_val("ill_odd_err", {31'd0, err0}, 32'd1);
    step();
    vld0 = 1'b0;
    #1;
    check_val("ill_ram_err", {31'd0, err0}, 32'd0);
    check_val("ill_ram_data", data0, 32'hABCD_1234);
    step();

    // Backdoor write colliding with a fetch of the same word
    wr_en = 1'b1; wr_addr = BASE + 32'd4; wr_data = 32'hFFFF_FFFF; wr_byte_en = 4'b0011;
    mem_addr = BASE + 32'd4; vld0 = 1'b1;
    step();
    wr_en = 1'b0;
    #1;
    check_val("col_old", data0, 32'hABCD_1234);
    step();
    vld0 = 1'b0;
    #1;
    check_val("col_new", data0, 32'hABCD_FFFF);
    step();
    check_val("col_cnt", {16'd0, cnt0}, 32'd10);

    // Reset during a stalled data phase
    mem_addr = BASE; vld0 = 1'b1; stall_in = 1'b1;
    step();
    vld0 = 1'b0;
    #1;
    check_val("rs_rdy_stall", {31'd0, rdy0}, 32'd0);
    check_val("rs_dv_stall", {31'd0, dv0}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("rs_async_rdy", {31'd0, rdy0}, 32'd1);
    check_val("rs_async_dv", {31'd0, dv0}, 32'd0);
    check_val("rs_async_data", data0, 32'd0);
    check_val("rs_async_cnt", {16'd0, cnt0}, 32'd0);
    step();
    step();
    #2 rst = 1'b0; stall_in = 1'b0;
    step();
    check_val("rs_no_ghost", {31'd0, dv0}, 32'd0);
    vld0 = 1'b1;
    step();
    vld0 = 1'b0;
    #1;
    check_val("rs_new_dv", {31'd0, dv0}, 32'd1);
    check_val("rs_new_data", data0, 32'h0000_0013);
    step();
    check_val("rs_new_cnt", {16'd0, cnt0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
